// File: rtl/nco_pkg.sv
// nco_pkg: shared NCO/meter definitions: sample width, meter states, threshold helpers
package nco_pkg;

    localparam int NCO_DATA_W = 8;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    function automatic int mid_of(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int clamp_thr(input int v, input int w);
        return (v < 0) ? 0 : ((v > (1 << w) - 1) ? (1 << w) - 1 : v);
    endfunction

endpackage

// File: rtl/nco_xing_det.sv
// nco_xing_det: rising midscale crossing detector; FREQ_METER_HYST_EN adds a +/-HYST band
module nco_xing_det
    import nco_pkg::*;
#(
    parameter int DATA_W = NCO_DATA_W,
    parameter int HYST   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              restart,
    output logic              xing
);

`ifdef FREQ_METER_HYST_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif

    localparam int                H  = HYST_EN ? HYST : 0;
    localparam logic [DATA_W-1:0] LO = DATA_W'(clamp_thr(mid_of(DATA_W) - H, DATA_W));
    localparam logic [DATA_W-1:0] HI = DATA_W'(clamp_thr(mid_of(DATA_W) + H, DATA_W));

    logic armed;

    assign xing = sample_valid && armed && (sample >= HI);

    // arm below the low threshold, disarm on the crossing it enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            armed <= 1'b0;
        else if (restart)
            armed <= 1'b0;
        else if (sample_valid)
            armed <= xing ? 1'b0 : ((sample < LO) ? 1'b1 : armed);
    end

endmodule

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: averages the period of rising midscale crossings over 2^AVG_LOG2 cycles
module nco_freq_meter
    import nco_pkg::*;
#(
    parameter int          DATA_W   = NCO_DATA_W,
    parameter int          CNT_W    = 24,
    parameter int          AVG_LOG2 = 2,
    parameter int          HYST     = 8,
    parameter int unsigned TIMEOUT  = 16777215
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         sample,
    input  logic                      sample_valid,
    input  logic                      restart,
    output logic [CNT_W-1:0]          period_avg,
    output logic [CNT_W+AVG_LOG2-1:0] period_sum,
    output logic                      meas_valid,
    output logic                      no_signal,
    output logic                      locked
);

    localparam int               SW   = CNT_W + AVG_LOG2;
    localparam int               IW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [IW-1:0]    LAST = IW'((1 << AVG_LOG2) - 1);

    meter_state_t     state, state_nxt;
    logic             xing, tout, last;
    logic [CNT_W-1:0] cnt, period;
    logic [SW-1:0]    acc, acc_nxt;
    logic [IW-1:0]    idx;

    nco_xing_det #(.DATA_W(DATA_W), .HYST(HYST)) u_det (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .restart      (restart),
        .xing         (xing)
    );

    assign period  = (&cnt) ? cnt : cnt + 1'b1;
    assign acc_nxt = acc + SW'(period);
    assign tout    = sample_valid && !xing && (state == MEASURE) && (cnt == TMO);
    assign last    = (idx == LAST);
    assign locked  = (state == MEASURE);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    // restart beats everything; a crossing beats a coincident timeout
    always_comb begin
        state_nxt = state;
        if (restart)
            state_nxt = SEARCH;
        else if (xing)
            state_nxt = MEASURE;
        else if (tout)
            state_nxt = SEARCH;
    end

    // sample counter, period accumulator and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            period_avg <= '0;
            period_sum <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else if (restart) begin
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (sample_valid) begin
                cnt <= xing ? '0 : ((cnt == TMO) ? cnt : cnt + 1'b1);
                if (xing && state == MEASURE) begin
                    idx <= last ? '0 : idx + 1'b1;
                    acc <= last ? '0 : acc_nxt;
                    if (last) begin
                        period_sum <= acc_nxt;
                        period_avg <= acc_nxt[SW-1:AVG_LOG2];
                        meas_valid <= 1'b1;
                        no_signal  <= 1'b0;
                    end
                end else if (xing || tout) begin
                    acc <= '0;
                    idx <= '0;
                    if (tout)
                        no_signal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: randomized and directed checks of nco_freq_meter against a period-list model
module tb_nco_freq_meter;

    localparam int TMO = 100;
`ifdef FREQ_METER_HYST_EN
    localparam int LO = 120;
    localparam int HI = 136;
    localparam int NOISE_AVG = 16;
`else
    localparam int LO = 128;
    localparam int HI = 128;
    localparam int NOISE_AVG = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sample = '0;
    logic        sample_valid = 1'b0;
    logic        restart = 1'b0;
    logic [23:0] period_avg;
    logic [25:0] period_sum;
    logic        meas_valid, no_signal, locked;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    logic [23:0] last_avg = '0;
    logic [25:0] last_sum = '0;

    always #5 clk = ~clk;

    nco_freq_meter #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .restart      (restart),
        .period_avg   (period_avg),
        .period_sum   (period_sum),
        .meas_valid   (meas_valid),
        .no_signal    (no_signal),
        .locked       (locked)
    );

    bit          m_armed = 0, m_locked = 0, e_mv = 0, e_ns = 0;
    longint      n = 0, last_n = 0;
    int          q[$];
    logic [23:0] e_avg = '0;
    logic [25:0] e_sum = '0;

    // model: crossing index list -> periods -> group-of-4 averages
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_armed = 0; m_locked = 0; e_mv = 0; e_ns = 0;
            e_avg = '0; e_sum = '0; q.delete();
        end else begin
            e_mv = 0;
            if (restart) begin
                m_armed = 0; m_locked = 0; e_ns = 0;
            end else if (sample_valid) begin
                bit x;
                n++;
                x = m_armed && (int'(sample) >= HI);
                if (x) m_armed = 0;
                else if (int'(sample) < LO) m_armed = 1;
                if (x) begin
                    if (!m_locked) begin
                        m_locked = 1;
                        q.delete();
                    end else begin
                        q.push_back(int'(n - last_n));
                        if (q.size() == 4) begin
                            int s;
                            s = 0;
                            foreach (q[i]) s += q[i];
                            e_sum = 26'(s);
                            e_avg = 24'(s >> 2);
                            e_mv = 1;
                            e_ns = 0;
                            q.delete();
                        end
                    end
                    last_n = n;
                end else if (m_locked && (n - last_n) == TMO + 1) begin
                    e_ns = 1;
                    m_locked = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("meas_valid", 64'(meas_valid), 64'(e_mv));
        chk("period_avg", 64'(period_avg), 64'(e_avg));
        chk("period_sum", 64'(period_sum), 64'(e_sum));
        chk("no_signal",  64'(no_signal),  64'(e_ns));
        chk("locked",     64'(locked),     64'(m_locked));
    end

    // capture of the most recent strobe for directed literal checks
    always @(negedge clk) begin
        if (meas_valid) begin
            strobes++;
            last_avg = period_avg;
            last_sum = period_sum;
        end
    end

    task automatic wave(input int p, input int periods, input int mode);
        int k, ph;
        bit v;
        k = 0;
        ph = 0;
        while (ph < p * periods) begin
            @(posedge clk); #1;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(k % 2) : ($urandom_range(0, 3) != 0);
            k++;
            sample = 8'(((ph % p) * 256) / p);
            sample_valid = v;
            if (v) ph++;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic noise(input int periods);
        logic [7:0] tbl[16];
        for (int i = 0; i < 16; i++) tbl[i] = 8'(i * 16);
        tbl[8] = 8'h84;
        tbl[9] = 8'h7C;
        for (int i = 0; i < periods * 16; i++) begin
            @(posedge clk); #1;
            sample = tbl[i % 16];
            sample_valid = 1'b1;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic konst(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            sample = 8'h80;
            sample_valid = 1'b1;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2;
        rst = 1'b0;
        sample_valid = 1'b0;
        #1;
        chk("rst_mid_avg", 64'(period_avg), 64'd0);
        chk("rst_mid_sum", 64'(period_sum), 64'd0);
        chk("rst_mid_locked", 64'(locked), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int s0, p;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_avg", 64'(period_avg), 64'd0);
        chk("reset_sum", 64'(period_sum), 64'd0);
        chk("reset_mv", 64'(meas_valid), 64'd0);
        chk("reset_ns", 64'(no_signal), 64'd0);
        chk("reset_locked", 64'(locked), 64'd0);
        rst = 1'b1;

        wave(16, 5, 0);
        chk("t1_first_strobe", 64'(strobes), 64'd1);
        chk("t1_avg", 64'(last_avg), 64'd16);
        chk("t1_sum", 64'(last_sum), 64'd64);
        chk("t1_locked", 64'(locked), 64'd1);
        chk("t1_ns", 64'(no_signal), 64'd0);

        pulse_restart();
        last_avg = '0;
        wave(16, 10, 1);
        chk("t2_avg", 64'(last_avg), 64'd16);
        chk("t2_sum", 64'(last_sum), 64'd64);

        wave(16, 2, 0);
        s0 = strobes;
        konst(110);
        chk("t3_ns_set", 64'(no_signal), 64'd1);
        chk("t3_unlocked", 64'(locked), 64'd0);
        chk("t3_no_strobe", 64'(strobes), 64'(s0));
        last_avg = '0;
        wave(16, 10, 0);
        chk("t3_ns_clear", 64'(no_signal), 64'd0);
        chk("t3_avg", 64'(last_avg), 64'd16);

        pulse_restart();
        last_avg = '0;
        noise(10);
        chk("t4_noise_avg", 64'(last_avg), 64'(NOISE_AVG));
        chk("t4_noise_sum", 64'(last_sum), 64'(NOISE_AVG * 4));

        pulse_restart();
        wave(16, 3, 0);
        pulse_restart();
        chk("t5_restart_locked", 64'(locked), 64'd0);
        chk("t5_restart_hold", 64'(period_avg), 64'(NOISE_AVG));
        last_avg = '0;
        wave(16, 10, 0);
        chk("t5_after_restart_avg", 64'(last_avg), 64'd16);
        chk("t5_after_restart_sum", 64'(last_sum), 64'd64);
        pulse_restart();
        wave(16, 3, 0);
        pulse_rst();
        last_avg = '0;
        wave(16, 10, 0);
        chk("t5_after_rst_avg", 64'(last_avg), 64'd16);
        chk("t5_after_rst_sum", 64'(last_sum), 64'd64);

        wave(16, 8, 0);
        wave(32, 10, 0);
        chk("t6_avg", 64'(last_avg), 64'd32);
        chk("t6_sum", 64'(last_sum), 64'd128);

        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(10, 40);
            last_avg = '0;
            wave(p, 10, 2);
            chk("rand_avg", 64'(last_avg), 64'(p));
            chk("rand_sum", 64'(last_sum), 64'(4 * p));
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
